rc_receiver: RTL and testbench



---
 rtl/rc_receiver.sv | 125 ++++++++++++
 tb/tb_rc_receiver.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/rc_receiver.sv
// RC servo/PWM pulse-width decoder: measures the high time of each pulse on an
// asynchronous input and reports validated widths, lock status and errors.
module rc_receiver #(
  parameter logic [11:0] MIN_PULSE      = 12'd800,
  parameter logic [11:0] MAX_PULSE      = 12'd2200,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd25_000,
  parameter logic [3:0]  LOCK_PULSES    = 4'd3,
  parameter logic [2:0]  SETTLE_CYCLES  = 3'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rc_in,
  output logic [11:0] pulse_duration,
  output logic        pulse_valid,
  output logic        new_pulse,
  output logic        signal_lost,
  output logic [7:0]  err_cnt
);

  localparam logic [1:0] S_WAIT_LOW = 2'd0;
  localparam logic [1:0] S_LOW      = 2'd1;
  localparam logic [1:0] S_HIGH     = 2'd2;

  logic [1:0]  state;
  logic        rc_m, rc_s, rc_d;
  logic [11:0] hi_cnt;
  logic [15:0] per_cnt;
  logic [3:0]  good_cnt;
  logic [2:0]  settle_cnt;
  logic        rise;
  logic        lock_reached;
  logic [7:0]  err_next;

  assign rise         = rc_s & ~rc_d;
  assign lock_reached = ({1'b0, good_cnt} + 5'd1) >= {1'b0, LOCK_PULSES};
  assign err_next     = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rc_m           <= 1'b0;
      rc_s           <= 1'b0;
      rc_d           <= 1'b0;
      state          <= S_WAIT_LOW;
      pulse_duration <= 12'd0;
      pulse_valid    <= 1'b0;
      new_pulse      <= 1'b0;
      signal_lost    <= 1'b1;
      err_cnt        <= 8'd0;
      hi_cnt         <= 12'd0;
      per_cnt        <= 16'd0;
      good_cnt       <= 4'd0;
      settle_cnt     <= 3'd0;
    end else begin
      rc_m      <= rc_in;
      rc_s      <= rc_m;
      rc_d      <= rc_s;
      new_pulse <= 1'b0;

      if (per_cnt != 16'hFFFF)
        per_cnt <= per_cnt + 16'd1;

      // Timeout is evaluated first so a same-cycle accept below overrides it.
      if (per_cnt == TIMEOUT_CYCLES) begin
        signal_lost <= 1'b1;
        pulse_valid <= 1'b0;
        good_cnt    <= 4'd0;
      end

      case (state)
        S_WAIT_LOW: begin
          if (rc_s) begin
            settle_cnt <= 3'd0;
          end else if (settle_cnt == SETTLE_CYCLES - 3'd1) begin
            state      <= S_LOW;
            settle_cnt <= 3'd0;
          end else begin
            settle_cnt <= settle_cnt + 3'd1;
          end
        end

        S_LOW: begin
          if (rise) begin
            state   <= S_HIGH;
            hi_cnt  <= 12'd1;
            per_cnt <= 16'd0;
          end
        end

        S_HIGH: begin
          if (rc_s) begin
            if (hi_cnt == MAX_PULSE) begin
              state       <= S_WAIT_LOW;
              err_cnt     <= err_next;
              good_cnt    <= 4'd0;
              pulse_valid <= 1'b0;
            end else begin
              hi_cnt <= hi_cnt + 12'd1;
            end
          end else begin
            state <= S_LOW;
            // hi_cnt can never exceed MAX_PULSE here, so only the lower bound needs testing.
            if (hi_cnt >= MIN_PULSE) begin
              pulse_duration <= hi_cnt;
              signal_lost    <= 1'b0;
              if (lock_reached) begin
                good_cnt    <= LOCK_PULSES;
                pulse_valid <= 1'b1;
                new_pulse   <= 1'b1;
              end else begin
                good_cnt <= good_cnt + 4'd1;
              end
            end else begin
              err_cnt     <= err_next;
              good_cnt    <= 4'd0;
              pulse_valid <= 1'b0;
            end
          end
        end

        default: state <= S_WAIT_LOW;
      endcase
    end
  end

endmodule

// File: tb/tb_rc_receiver.sv
// Directed testbench for rc_receiver: expected strobed widths go through a
// scoreboard queue; register-style outputs are checked at fixed points.
`timescale 1ns/1ps
module tb_rc_receiver;

  logic        clk;
  logic        rst_n;
  logic        rc_in;
  logic [11:0] pulse_duration;
  logic        pulse_valid;
  logic        new_pulse;
  logic        signal_lost;
  logic [7:0]  err_cnt;

  int checkCount  = 0;
  int passCount   = 0;
  int failCount   = 0;
  int strobeCount = 0;
  logic prevNew   = 1'b0;
  int expQ[$];

  rc_receiver dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rc_in          (rc_in),
    .pulse_duration (pulse_duration),
    .pulse_valid    (pulse_valid),
    .new_pulse      (new_pulse),
    .signal_lost    (signal_lost),
    .err_cnt        (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #(1_500_000 * 10);
    $display("[TB] FAIL watchdog: simulation did not finish within the cycle budget");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One pulse: rc_in high for 'high' clocks then low for 'low' clocks, driven on negedges.
  task automatic applyStimulus(input int high, input int low);
    @(negedge clk) rc_in = 1'b1;
    repeat (high - 1) @(negedge clk);
    @(negedge clk) rc_in = 1'b0;
    repeat (low - 1) @(negedge clk);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_duration"}, {4'd0, pulse_duration}, 16'd0);
    checkOutput({tag, "_valid"},    {15'd0, pulse_valid},   16'd0);
    checkOutput({tag, "_new"},      {15'd0, new_pulse},     16'd0);
    checkOutput({tag, "_lost"},     {15'd0, signal_lost},   16'd1);
    checkOutput({tag, "_err"},      {8'd0, err_cnt},        16'd0);
  endtask

  // Scoreboard side: every strobe must match the oldest queued expected width.
  always @(negedge clk) begin
    if (rst_n && new_pulse) begin
      strobeCount++;
      checkOutput("strobe_single_cycle", {15'd0, prevNew}, 16'd0);
      checkOutput("strobe_expected", {15'd0, (expQ.size() > 0)}, 16'd1);
      if (expQ.size() > 0)
        checkOutput("strobe_width", {4'd0, pulse_duration}, 16'(expQ.pop_front()));
    end
    prevNew = new_pulse;
  end

  initial begin
    rst_n = 1'b0;
    rc_in = 1'b0;
    repeat (3) @(negedge clk);
    checkResetValues("reset");
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Nominal pulse train and locking.
    applyStimulus(1500, 300);
    checkOutput("p1_duration", {4'd0, pulse_duration}, 16'd1500);
    checkOutput("p1_lost",     {15'd0, signal_lost},   16'd0);
    checkOutput("p1_valid",    {15'd0, pulse_valid},   16'd0);
    applyStimulus(1500, 300);
    checkOutput("p2_valid", {15'd0, pulse_valid}, 16'd0);
    expQ.push_back(1500);
    applyStimulus(1500, 300);
    checkOutput("p3_valid", {15'd0, pulse_valid}, 16'd1);
    expQ.push_back(1500);
    applyStimulus(1500, 300);
    expQ.push_back(1500);
    applyStimulus(1500, 300);
    checkOutput("p5_valid",    {15'd0, pulse_valid}, 16'd1);
    checkOutput("train_err",   {8'd0, err_cnt},      16'd0);
    checkOutput("train_strobes", 16'(strobeCount),   16'd3);

    // Width boundaries after lock.
    applyStimulus(799, 300);
    checkOutput("w799_err",      {8'd0, err_cnt},        16'd1);
    checkOutput("w799_valid",    {15'd0, pulse_valid},   16'd0);
    checkOutput("w799_duration", {4'd0, pulse_duration}, 16'd1500);
    applyStimulus(800, 300);
    checkOutput("w800_duration", {4'd0, pulse_duration}, 16'd800);
    checkOutput("w800_valid",    {15'd0, pulse_valid},   16'd0);
    checkOutput("w800_err",      {8'd0, err_cnt},        16'd1);
    applyStimulus(2200, 300);
    checkOutput("w2200_duration", {4'd0, pulse_duration}, 16'd2200);
    checkOutput("w2200_valid",    {15'd0, pulse_valid},   16'd0);

    @(negedge clk) rc_in = 1'b1;
    repeat (2202) @(negedge clk);
    checkOutput("w2201_before_abort", {8'd0, err_cnt}, 16'd1);
    @(negedge clk);
    checkOutput("w2201_at_abort", {8'd0, err_cnt}, 16'd2);
    repeat (97) @(negedge clk);
    rc_in = 1'b0;
    repeat (300) @(negedge clk);
    checkOutput("w2201_err_after",  {8'd0, err_cnt},        16'd2);
    checkOutput("w2201_duration",   {4'd0, pulse_duration}, 16'd2200);
    checkOutput("w2201_valid",      {15'd0, pulse_valid},   16'd0);

    // Relock, then hold rc_in low and time the loss-of-signal.
    applyStimulus(1500, 300);
    applyStimulus(1500, 300);
    expQ.push_back(1500);
    @(negedge clk) rc_in = 1'b1;
    repeat (1500) @(negedge clk);
    rc_in = 1'b0;
    repeat (25003 - 1500) @(negedge clk);
    checkOutput("timeout_lost_before",  {15'd0, signal_lost}, 16'd0);
    checkOutput("timeout_valid_before", {15'd0, pulse_valid}, 16'd1);
    @(negedge clk);
    checkOutput("timeout_lost",     {15'd0, signal_lost},   16'd1);
    checkOutput("timeout_valid",    {15'd0, pulse_valid},   16'd0);
    checkOutput("timeout_duration", {4'd0, pulse_duration}, 16'd1500);

    // rc_in already high across reset release: partial pulse must be ignored.
    @(negedge clk) begin
      rst_n = 1'b0;
      rc_in = 1'b1;
    end
    repeat (5) @(negedge clk);
    checkResetValues("reset_high");
    rst_n = 1'b1;
    repeat (1000) @(negedge clk);
    rc_in = 1'b0;
    repeat (500) @(negedge clk);
    checkOutput("partial_duration", {4'd0, pulse_duration}, 16'd0);
    checkOutput("partial_err",      {8'd0, err_cnt},        16'd0);
    applyStimulus(1500, 300);
    checkOutput("after_partial_duration", {4'd0, pulse_duration}, 16'd1500);
    checkOutput("after_partial_lost",     {15'd0, signal_lost},   16'd0);

    // Reset asserted in the middle of a pulse.
    @(negedge clk) rc_in = 1'b1;
    repeat (700) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkResetValues("mid_reset");
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (795) @(negedge clk);
    rc_in = 1'b0;
    repeat (500) @(negedge clk);
    checkOutput("mid_reset_duration", {4'd0, pulse_duration}, 16'd0);
    checkOutput("mid_reset_err",      {8'd0, err_cnt},        16'd0);
    checkOutput("mid_reset_valid",    {15'd0, pulse_valid},   16'd0);

    // Short glitches drive the error counter into saturation.
    for (int i = 0; i < 255; i++) applyStimulus(100, 4);
    repeat (5) @(negedge clk);
    checkOutput("glitch_err_255", {8'd0, err_cnt}, 16'd255);
    for (int i = 0; i < 45; i++) applyStimulus(100, 4);
    repeat (5) @(negedge clk);
    checkOutput("glitch_err_sat",   {8'd0, err_cnt},        16'd255);
    checkOutput("glitch_valid",     {15'd0, pulse_valid},   16'd0);
    checkOutput("glitch_duration",  {4'd0, pulse_duration}, 16'd0);

    checkOutput("total_strobes", 16'(strobeCount), 16'd4);
    checkOutput("scoreboard_empty", 16'(expQ.size()), 16'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
